// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master among four requesters.
// Latches the winner's transaction and guards it with a per-transaction watchdog.
module i2c_master_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [27:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_rw,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        timeout,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic [7:0]  m_data,
  output logic        m_rw,
  input  logic        m_busy,
  input  logic        m_ack_error,
  input  logic [7:0]  m_data_out
);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e      state;
  logic [1:0]  last_granted;
  logic [1:0]  cur_idx;
  logic [15:0] watchdog;

  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [1:0]  cand;
  logic [6:0]  sel_addr;
  logic [7:0]  sel_data;
  logic        sel_rw;
  logic        expired;

  // Search starts one past the last winner; k = 4 wraps back to last_granted itself.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_granted + 2'(k);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_rw   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sel_idx == 2'(i)) begin
        sel_addr = req_addr[7*i +: 7];
        sel_data = req_wdata[8*i +: 8];
        sel_rw   = req_rw[i];
      end
    end
  end

  assign expired = (watchdog + 16'd1) == 16'(TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      last_granted <= 2'd3;
      cur_idx      <= 2'd0;
      watchdog     <= '0;
      gnt          <= '0;
      done         <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      timeout      <= 1'b0;
      m_start      <= 1'b0;
      m_addr       <= '0;
      m_data       <= '0;
      m_rw         <= 1'b0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (sel_valid) begin
            gnt      <= 4'b0001 << sel_idx;
            cur_idx  <= sel_idx;
            m_addr   <= sel_addr;
            m_data   <= sel_data;
            m_rw     <= sel_rw;
            m_start  <= 1'b1;
            watchdog <= '0;
            state    <= StWaitBusy;
          end
        end
        StWaitBusy, StWaitDone: begin
          watchdog <= watchdog + 16'd1;
          // A genuine completion wins over a watchdog expiry on the same edge.
          if (state == StWaitDone && !m_busy) begin
            done         <= gnt;
            rsp_rdata    <= m_data_out;
            rsp_err      <= m_ack_error;
            gnt          <= '0;
            last_granted <= cur_idx;
            state        <= StIdle;
          end else if (expired) begin
            done         <= gnt;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b1;
            timeout      <= 1'b1;
            gnt          <= '0;
            last_granted <= cur_idx;
            state        <= StIdle;
          end else if (state == StWaitBusy && m_busy) begin
            state <= StWaitDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized bench for i2c_master_arbiter: a transaction-level model predicts grant order,
// completion cycle and response, with a simple master responder driven from the bench.
module tb_i2c_master_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rw;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        timeout;
  logic        m_start;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_rw;
  logic        m_busy;
  logic        m_ack_error;
  logic [7:0]  m_data_out;

  int total = 0;
  int bad   = 0;

  // Model state: one transaction in flight at most.
  bit         active  = 1'b0;
  bit         rand_on = 1'b1;
  int         last_g  = 3;
  int         g       = 0;
  int         since   = 0;
  int         lat     = 0;     // 0 = master never goes busy
  logic [6:0] c_addr;
  logic [7:0] c_data;
  logic       c_rw;
  logic [7:0] c_rdata;
  logic       c_err;
  int         lat_of [4];
  logic [7:0] rd_of [4];
  logic       ae_of [4];

  always #5 clk = ~clk;

  i2c_master_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rw      (req_rw),
    .gnt         (gnt),
    .done        (done),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .timeout     (timeout),
    .m_start     (m_start),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_rw        (m_rw),
    .m_busy      (m_busy),
    .m_ack_error (m_ack_error),
    .m_data_out  (m_data_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic raise(input int i);
    req[i]               = 1'b1;
    req_addr[7*i +: 7]   = 7'($urandom);
    req_wdata[8*i +: 8]  = 8'($urandom);
    req_rw[i]            = 1'($urandom);
    lat_of[i]            = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 14));
    rd_of[i]             = 8'($urandom);
    ae_of[i]             = 1'($urandom);
  endtask

  task automatic step();
    logic [3:0] req_before;
    int         p;
    int         exp_at;
    bit         timed;
    req_before = req;
    @(posedge clk);
    #1;
    if (!active) begin
      check_eq("idle_done", 32'(done), 32'd0);
      check_eq("idle_timeout", 32'(timeout), 32'd0);
      p = rr_pick(req_before, last_g);
      if (p < 0) begin
        check_eq("idle_gnt", 32'(gnt), 32'd0);
      end else begin
        check_eq("grant", 32'(gnt), 32'(1) << p);
        check_eq("start", 32'(m_start), 32'd1);
        check_eq("grant_addr", 32'(m_addr), 32'(req_addr[7*p +: 7]));
        check_eq("grant_data", 32'(m_data), 32'(req_wdata[8*p +: 8]));
        check_eq("grant_rw", 32'(m_rw), 32'(req_rw[p]));
        active  = 1'b1;
        g       = p;
        since   = 0;
        c_addr  = req_addr[7*p +: 7];
        c_data  = req_wdata[8*p +: 8];
        c_rw    = req_rw[p];
        lat     = lat_of[p];
        c_rdata = rd_of[p];
        c_err   = ae_of[p];
      end
    end else begin
      since++;
      timed  = (lat == 0) || (lat + 2 > TO);
      exp_at = timed ? TO : lat + 2;
      check_eq("start_one_cycle", 32'(m_start), 32'd0);
      check_eq("hold", 32'({m_addr, m_data, m_rw}), 32'({c_addr, c_data, c_rw}));
      if (since == exp_at) begin
        check_eq("done", 32'(done), 32'(1) << g);
        check_eq("gnt_clear", 32'(gnt), 32'd0);
        check_eq("rsp_rdata", 32'(rsp_rdata), timed ? 32'd0 : 32'(c_rdata));
        check_eq("rsp_err", 32'(rsp_err), timed ? 32'd1 : 32'(c_err));
        check_eq("timeout", 32'(timeout), 32'(timed));
        active = 1'b0;
        last_g = g;
        if (req[g] && rand_on && $urandom_range(0, 2) == 0) raise(g);
        else req[g] = 1'b0;
      end else begin
        check_eq("early_done", 32'(done), 32'd0);
        check_eq("early_timeout", 32'(timeout), 32'd0);
        check_eq("gnt_hold", 32'(gnt), 32'(1) << g);
        // Abandoned request with a scrambled payload must not disturb the transaction.
        if (rand_on && req[g] && $urandom_range(0, 9) == 0) begin
          req[g]              = 1'b0;
          req_addr[7*g +: 7]  = ~c_addr;
          req_wdata[8*g +: 8] = ~c_data;
          req_rw[g]           = ~c_rw;
        end
      end
    end
    if (active) begin
      if (since == 0) begin
        m_busy = 1'b0;
      end else if (lat != 0) begin
        if (since == 1) begin
          m_busy      = 1'b1;
          m_data_out  = 8'($urandom);
          m_ack_error = 1'($urandom);
        end
        if (since == 1 + lat) begin
          m_busy      = 1'b0;
          m_data_out  = c_rdata;
          m_ack_error = c_err;
        end
      end
    end else begin
      m_busy = rand_on && ($urandom_range(0, 3) == 0);
    end
    if (rand_on) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && !(active && i == g) && $urandom_range(0, 7) == 0) raise(i);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    req         = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_rw      = '0;
    m_busy      = 1'b0;
    m_ack_error = 1'b0;
    m_data_out  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctl", 32'({gnt, done, rsp_rdata, rsp_err, timeout, m_start}), 32'd0);
    check_eq("reset_bus", 32'({m_addr, m_data, m_rw}), 32'd0);
    rst = 1'b0;

    repeat (3000) step();

    rand_on = 1'b0;
    req     = '0;
    for (int n = 0; n < 40 && active; n++) step();
    check_eq("drained_gnt", 32'(gnt), 32'd0);

    // Abort a requester-1 transaction five cycles in.
    raise(1);
    lat_of[1] = 0;
    repeat (5) step();
    check_eq("pre_abort_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1;
    #1;
    check_eq("abort_ctl", 32'({gnt, done, rsp_rdata, rsp_err, timeout, m_start}), 32'd0);
    check_eq("abort_bus", 32'({m_addr, m_data, m_rw}), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_done", 32'(done), 32'd0);
    end
    active = 1'b0;
    last_g = 3;
    m_busy = 1'b0;
    raise(0);
    rst = 1'b0;
    step();
    check_eq("post_reset_first", 32'(gnt), 32'b0001);
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, is the watchdog limit in clk cycles per transaction (legal range 2..65535).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester transaction request, held by the requester until its done pulse.
REQ-005 req_addr  input  28  four 7-bit slave addresses; requester i uses bits [7i+6:7i].
REQ-006 req_wdata  input  32  four write bytes; requester i uses bits [8i+7:8i].
REQ-007 req_rw  input  4  per-requester direction: 0 = write, 1 = read.
REQ-008 gnt  output  4  one-hot grant, high for the whole transaction of the granted requester.
REQ-009 done  output  4  one-cycle completion pulse to the granted requester.
REQ-010 rsp_rdata  output  8  read byte captured at completion, valid while done is high.
REQ-011 rsp_err  output  1  NACK or timeout indication, valid while done is high.
REQ-012 timeout  output  1  one-cycle pulse when the watchdog expires.
REQ-013 m_start  output  1  start strobe to the shared I2C master.
REQ-014 m_addr  output  7  slave address to the master.
REQ-015 m_data  output  8  write byte to the master.
REQ-016 m_rw  output  1  direction to the master.
REQ-017 m_busy  input  1  master busy flag; rises the cycle after m_start is accepted.
REQ-018 m_ack_error  input  1  master NACK flag; valid when m_busy falls.
REQ-019 m_data_out  input  8  master read byte; valid when m_busy falls.

Function
REQ-020 The arbiter SHALL implement three states: IDLE, WAIT_BUSY and WAIT_DONE; only IDLE may issue a grant.
REQ-021 In IDLE with any req bit high, the arbiter SHALL select by round-robin starting at index (last_granted+1) mod 4; after reset the search SHALL start at index 0.
REQ-022 On the selecting edge, gnt SHALL be set one-hot, m_addr, m_data and m_rw SHALL be latched from the selected requester's slice, m_start SHALL be set to 1, and the state SHALL go to WAIT_BUSY.
REQ-023 m_start SHALL be high for exactly one cycle per transaction.
REQ-024 m_addr, m_data, m_rw and gnt SHALL stay stable from grant until the done cycle, whatever req or req_* inputs do in that time.
REQ-025 In WAIT_BUSY, m_busy=1 SHALL move the state to WAIT_DONE.
REQ-026 In WAIT_DONE, m_busy=0 SHALL complete the transaction:
  - done[g] pulses for one cycle;
  - rsp_rdata takes m_data_out;
  - rsp_err takes m_ack_error;
  - gnt clears;
  - last_granted takes g;
  - the state returns to IDLE.
REQ-027 A 16-bit watchdog SHALL clear on grant and increment each cycle in WAIT_BUSY and WAIT_DONE.
REQ-028 When the watchdog reaches TIMEOUT, the transaction SHALL complete as in REQ-026, except that rsp_err=1, rsp_rdata=0 and timeout pulses for one cycle.
REQ-029 If completion and watchdog expiry fall on the same cycle, completion by m_busy SHALL take priority and timeout SHALL stay low.
REQ-030 Deasserting req mid-transaction SHALL NOT abort the transaction; done SHALL still pulse.
REQ-031 Completion to next grant SHALL take one cycle: the next grant occurs on the edge after the done cycle at the earliest.
REQ-032 A requester whose req stays high after done SHALL be re-queued and granted only after the other pending requesters under round-robin.
REQ-033 m_busy seen high while in IDLE SHALL be ignored and SHALL NOT block a grant.

Reset
REQ-034 While rst is high, the arbiter SHALL hold: state IDLE; gnt=0, done=0, rsp_rdata=0x00, rsp_err=0, timeout=0, m_start=0, m_addr=0, m_data=0, m_rw=0; watchdog=0; last_granted=3.
REQ-035 Reset asserted mid-transaction SHALL abort at once, with no done pulse; after release, the first grant SHALL follow REQ-021.

Verification
REQ-036 req=0001, addr0=0x50, wdata0=0xA5, rw0=0, master model: busy 1 cycle after start, low after 20 cycles, ack_error=0 -> gnt=0001 and m_start for one cycle with m_addr=0x50, m_data=0xA5; done=0001 with rsp_err=0.
REQ-037 req=1111 held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; exactly one gnt bit high at a time; at least one idle cycle between transactions.
REQ-038 Read from requester 2 with the master returning m_data_out=0x3C, ack_error=1 -> done=0100, rsp_rdata=0x3C, rsp_err=1.
REQ-039 TIMEOUT=15, master never raises busy -> timeout and done[g] pulse 15 cycles after grant with rsp_err=1; the next pending requester is then granted normally.
REQ-040 Reset pulsed 5 cycles into a requester-1 transaction -> all outputs 0 with no done pulse; with req=0011 after release, requester 0 is granted first.
REQ-041 req[1] dropped and req_addr changed mid-transaction -> m_addr unchanged and done[1] still pulses.
